// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
//   - state_t    : controller FSM states
//   - alu_cls_t  : which class of ALU operation the current state needs
//   - ALU_*      : 4-bit ALU operation codes
//   - OP_* / FN_*: opcode and funct field values of the supported instructions
//   - ALUB_*     : operand-B select encodings
//   - PCS_*      : next-PC source encodings
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    // ADD: address/PC arithmetic, SUB: branch compare,
    // RTYPE: taken from funct, ITYPE: taken from opcode
    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_RTYPE,
        CLS_ITYPE
    } alu_cls_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_MUL   = 6'h1C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MUL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [1:0] ALUB_B      = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_op_decode.sv
// Combinational ALU operation decoder.
//   alu_cls     in  2  operation class requested by the current state
//   opcode      in  6  IR[31:26]
//   funct       in  6  IR[5:0]
//   alu_ctrl    out 4  ALU operation code
//   funct_valid out 1  opcode/funct pair is a supported R-type or mul
module mips_alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  alu_cls_t   alu_cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       funct_valid
);

    logic [3:0] r_op;
    logic [3:0] i_op;

    always_comb begin
        r_op        = ALU_ADD;
        funct_valid = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  begin r_op = ALU_ADD; funct_valid = 1'b1; end
                FN_SUB:  begin r_op = ALU_SUB; funct_valid = 1'b1; end
                FN_AND:  begin r_op = ALU_AND; funct_valid = 1'b1; end
                FN_OR:   begin r_op = ALU_OR;  funct_valid = 1'b1; end
                default: begin r_op = ALU_ADD; funct_valid = 1'b0; end
            endcase
        end else if (opcode == OP_MUL && funct == FN_MUL) begin
            r_op        = ALU_MUL;
            funct_valid = 1'b1;
        end
    end

    always_comb begin
        case (opcode)
            OP_ANDI: i_op = ALU_AND;
            OP_ORI:  i_op = ALU_OR;
            default: i_op = ALU_ADD;
        endcase
    end

    always_comb begin
        case (alu_cls)
            CLS_SUB:   alu_ctrl = ALU_SUB;
            CLS_RTYPE: alu_ctrl = r_op;
            CLS_ITYPE: alu_ctrl = i_op;
            default:   alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// selects, register enables, memory strobes and ALU operation code.
//   clk, rst                         clock, asynchronous active-high reset
//   opcode, funct                    IR fields
//   flag_zero                        ALU zero flag (branch resolution)
//   mem_ready                        memory completes the request this cycle
//   mem_req/mem_read/mem_write       memory request strobes
//   i_or_d                           memory address select (0 PC, 1 ALUOut)
//   ir_write/pc_write/reg_write      register enables
//   reg_dst, mem_to_reg, ext_zero    writeback / immediate selects
//   alu_src_a, alu_src_b, alu_ctrl   ALU operand selects and operation
//   pc_source                        next-PC select
//   instr_done                       pulse in the last cycle of an instruction
//   illegal_op                       trap indicator, held until reset
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       flag_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       ext_zero,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state;
    state_t     state_nxt;
    alu_cls_t   alu_cls;
    logic [3:0] dec_alu_ctrl;
    logic       funct_valid;
    logic       is_logic_imm;
    logic       br_taken;

    assign is_logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign br_taken     = ((opcode == OP_BEQ) &&  flag_zero) ||
                          ((opcode == OP_BNE) && !flag_zero);

    always_comb begin
        case (state)
            S_R_EXEC: alu_cls = CLS_RTYPE;
            S_I_EXEC: alu_cls = CLS_ITYPE;
            S_BRANCH: alu_cls = CLS_SUB;
            default:  alu_cls = CLS_ADD;
        endcase
    end

    mips_alu_op_decode u_alu_op_decode (
        .alu_cls     (alu_cls),
        .opcode      (opcode),
        .funct       (funct),
        .alu_ctrl    (dec_alu_ctrl),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:              state_nxt = S_MEM_ADDR;
                    OP_RTYPE, OP_MUL:          state_nxt = funct_valid ? S_R_EXEC : S_TRAP;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_nxt = S_I_EXEC;
                    OP_BEQ, OP_BNE:            state_nxt = S_BRANCH;
                    OP_J:                      state_nxt = S_JUMP;
                    default:                   state_nxt = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WB:   state_nxt = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
            S_R_EXEC:   state_nxt = S_R_WB;
            S_R_WB:     state_nxt = S_FETCH;
            S_I_EXEC:   state_nxt = S_I_WB;
            S_I_WB:     state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JUMP:     state_nxt = S_FETCH;
            S_TRAP:     state_nxt = S_TRAP;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Outputs follow the state directly so an asynchronous reset clears
    // them in the same cycle; only the FETCH/BRANCH/MEM_WR handshakes
    // look at mem_ready or flag_zero.
    always_comb begin
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        ext_zero   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_B;
        alu_ctrl   = dec_alu_ctrl;
        pc_source  = PCS_ALU;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_IDLE: alu_ctrl = 4'b0000;
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = ALUB_IMM_SH;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: alu_src_a = 1'b1;
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                ext_zero  = is_logic_imm;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                ext_zero   = is_logic_imm;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                pc_source  = PCS_ALUOUT;
                pc_write   = br_taken;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_source  = PCS_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP: begin
                alu_ctrl   = 4'b0000;
                illegal_op = 1'b1;
            end
            default: alu_ctrl = 4'b0000;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed testbench for mips_mc_ctrl. All outputs are packed into one
// 21-bit word and compared per cycle against hand-written constants:
//   {req rd wr iod}_{irw pcw rgw rdst}_{m2r ez asa}_{asb}_{aluc}_{pcs}_{done ill}
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       flag_zero;
    logic       mem_ready;
    logic       mem_req, mem_read, mem_write, i_or_d;
    logic       ir_write, pc_write, reg_write, reg_dst;
    logic       mem_to_reg, ext_zero, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] pc_source;
    logic       instr_done, illegal_op;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [20:0] W_ZERO      = 21'b0000_0000_000_00_0000_00_00;
    localparam logic [20:0] W_FETCH_W   = 21'b1100_0000_000_01_0010_00_00;
    localparam logic [20:0] W_FETCH     = 21'b1100_1100_000_01_0010_00_00;
    localparam logic [20:0] W_DECODE    = 21'b0000_0000_000_11_0010_00_00;
    localparam logic [20:0] W_REX_ADD   = 21'b0000_0000_001_00_0010_00_00;
    localparam logic [20:0] W_REX_SUB   = 21'b0000_0000_001_00_0011_00_00;
    localparam logic [20:0] W_REX_MUL   = 21'b0000_0000_001_00_0100_00_00;
    localparam logic [20:0] W_R_WB      = 21'b0000_0011_000_00_0010_00_10;
    localparam logic [20:0] W_MEM_ADDR  = 21'b0000_0000_001_10_0010_00_00;
    localparam logic [20:0] W_MEM_RD    = 21'b1101_0000_000_00_0010_00_00;
    localparam logic [20:0] W_MEM_WB    = 21'b0000_0010_100_00_0010_00_10;
    localparam logic [20:0] W_MEM_WR_W  = 21'b1011_0000_000_00_0010_00_00;
    localparam logic [20:0] W_MEM_WR    = 21'b1011_0000_000_00_0010_00_10;
    localparam logic [20:0] W_IEX_ORI   = 21'b0000_0000_011_10_0001_00_00;
    localparam logic [20:0] W_IWB_ORI   = 21'b0000_0010_010_00_0010_00_10;
    localparam logic [20:0] W_BR_TAKEN  = 21'b0000_0100_001_00_0011_01_10;
    localparam logic [20:0] W_BR_NOT    = 21'b0000_0000_001_00_0011_01_10;
    localparam logic [20:0] W_JUMP      = 21'b0000_0100_000_00_0010_10_10;
    localparam logic [20:0] W_TRAP      = 21'b0000_0000_000_00_0000_00_01;

    logic [20:0] obs;
    assign obs = {mem_req, mem_read, mem_write, i_or_d,
                  ir_write, pc_write, reg_write, reg_dst,
                  mem_to_reg, ext_zero, alu_src_a,
                  alu_src_b, alu_ctrl, pc_source, instr_done, illegal_op};

    mips_mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .flag_zero  (flag_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .ext_zero   (ext_zero),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .pc_source  (pc_source),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Called just after a rising edge: apply inputs, check mid-cycle,
    // then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic rdy, input logic fz, input logic [20:0] exp);
        mem_ready = rdy;
        flag_zero = fz;
        @(negedge clk);
        chk_eq(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h20;
        flag_zero = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk_eq("reset", obs, W_ZERO);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("idle", 1'b1, 1'b0, W_ZERO);

        // add, zero-wait
        set_instr(6'h00, 6'h20);
        cyc("add_fetch",  1'b1, 1'b0, W_FETCH);
        cyc("add_decode", 1'b1, 1'b0, W_DECODE);
        cyc("add_exec",   1'b1, 1'b0, W_REX_ADD);
        cyc("add_wb",     1'b1, 1'b0, W_R_WB);

        // lw, two wait cycles in MEM_RD
        set_instr(6'h23, 6'h00);
        cyc("lw_fetch",  1'b1, 1'b0, W_FETCH);
        cyc("lw_decode", 1'b1, 1'b0, W_DECODE);
        cyc("lw_addr",   1'b1, 1'b0, W_MEM_ADDR);
        cyc("lw_rd_w1",  1'b0, 1'b0, W_MEM_RD);
        cyc("lw_rd_w2",  1'b0, 1'b0, W_MEM_RD);
        cyc("lw_rd",     1'b1, 1'b0, W_MEM_RD);
        cyc("lw_wb",     1'b1, 1'b0, W_MEM_WB);

        // beq taken
        set_instr(6'h04, 6'h00);
        cyc("beq_fetch",  1'b1, 1'b1, W_FETCH);
        cyc("beq_decode", 1'b1, 1'b1, W_DECODE);
        cyc("beq_branch", 1'b1, 1'b1, W_BR_TAKEN);

        // bne with zero flag set: not taken
        set_instr(6'h05, 6'h00);
        cyc("bne_fetch",  1'b1, 1'b1, W_FETCH);
        cyc("bne_decode", 1'b1, 1'b1, W_DECODE);
        cyc("bne_branch", 1'b1, 1'b1, W_BR_NOT);

        // ori
        set_instr(6'h0D, 6'h00);
        cyc("ori_fetch",  1'b1, 1'b0, W_FETCH);
        cyc("ori_decode", 1'b1, 1'b0, W_DECODE);
        cyc("ori_exec",   1'b1, 1'b0, W_IEX_ORI);
        cyc("ori_wb",     1'b1, 1'b0, W_IWB_ORI);

        // mul
        set_instr(6'h1C, 6'h02);
        cyc("mul_fetch",  1'b1, 1'b0, W_FETCH);
        cyc("mul_decode", 1'b1, 1'b0, W_DECODE);
        cyc("mul_exec",   1'b1, 1'b0, W_REX_MUL);
        cyc("mul_wb",     1'b1, 1'b0, W_R_WB);

        // sw, one wait cycle in MEM_WR
        set_instr(6'h2B, 6'h00);
        cyc("sw_fetch",  1'b1, 1'b0, W_FETCH);
        cyc("sw_decode", 1'b1, 1'b0, W_DECODE);
        cyc("sw_addr",   1'b1, 1'b0, W_MEM_ADDR);
        cyc("sw_wr_w",   1'b0, 1'b0, W_MEM_WR_W);
        cyc("sw_wr",     1'b1, 1'b0, W_MEM_WR);

        // j
        set_instr(6'h02, 6'h00);
        cyc("j_fetch",  1'b1, 1'b0, W_FETCH);
        cyc("j_decode", 1'b1, 1'b0, W_DECODE);
        cyc("j_jump",   1'b1, 1'b0, W_JUMP);

        // sub with one fetch wait
        set_instr(6'h00, 6'h22);
        cyc("sub_fetch_w", 1'b0, 1'b0, W_FETCH_W);
        cyc("sub_fetch",   1'b1, 1'b0, W_FETCH);
        cyc("sub_decode",  1'b1, 1'b0, W_DECODE);
        cyc("sub_exec",    1'b1, 1'b0, W_REX_SUB);
        cyc("sub_wb",      1'b1, 1'b0, W_R_WB);

        // unsupported opcode: trap is sticky regardless of inputs
        set_instr(6'h3F, 6'h00);
        cyc("bad_op_fetch",  1'b1, 1'b0, W_FETCH);
        cyc("bad_op_decode", 1'b1, 1'b0, W_DECODE);
        for (int i = 0; i < 12; i++) begin
            cyc("bad_op_trap", i[0], i[1], W_TRAP);
        end
        rst = 1'b1;
        #1;
        chk_eq("trap_rst", obs, W_ZERO);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("trap_idle", 1'b1, 1'b0, W_ZERO);

        // unsupported funct under R-type
        set_instr(6'h00, 6'h21);
        cyc("bad_fn_fetch",  1'b1, 1'b0, W_FETCH);
        cyc("bad_fn_decode", 1'b1, 1'b0, W_DECODE);
        for (int i = 0; i < 10; i++) begin
            cyc("bad_fn_trap", 1'b1, 1'b0, W_TRAP);
        end
        rst = 1'b1;
        #1;
        chk_eq("trap2_rst", obs, W_ZERO);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("trap2_idle", 1'b1, 1'b0, W_ZERO);

        // reset in the middle of a stalled store
        set_instr(6'h2B, 6'h00);
        cyc("swr_fetch",  1'b1, 1'b0, W_FETCH);
        cyc("swr_decode", 1'b1, 1'b0, W_DECODE);
        cyc("swr_addr",   1'b1, 1'b0, W_MEM_ADDR);
        mem_ready = 1'b0;
        @(negedge clk);
        chk_eq("swr_wr_w", obs, W_MEM_WR_W);
        rst = 1'b1;
        #1;
        chk_eq("swr_async_rst", obs, W_ZERO);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("swr_idle",  1'b0, 1'b0, W_ZERO);
        cyc("swr_fetch_again", 1'b0, 1'b0, W_FETCH_W);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
